debug_dump_sequencer: RTL
=========================

Name: debug_dump_sequencer

Overview:
- Sequences the post-halt/post-step state readout from the segmented MIPS pipeline to the UART transmitter.
- Walks PC, cycle counter, all 32 registers, then every dirty data-memory word, driving the register-file and data-memory debug read ports.
- Serializes each value into bytes and hands them one at a time to the UART TX.
- Sits inside debug_unit, between its command FSM and its UART TX.

Parameters:
- NB_DATA, 32, register/memory word width
- NB_PC, 32, PC width; zero-extended to 32 bits on the wire
- N_BITS, 8, cycle-counter width and UART byte width
- NB_REG, 5, register address width
- NB_MEM_ADDR, 5, data-memory word address width
- MEM_DEPTH, 32, number of data-memory words scanned; must be <=255
- END_MARKER, 8'hFF, frame terminator byte

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  asynchronous, active-low reset
- start_i  in  1  1-cycle pulse: begin dump; ignored while busy_o=1
- pc_i  in  NB_PC  current PC
- cycles_i  in  N_BITS  executed-cycle count
- reg_data_i  in  NB_DATA  register-file debug read data
- mem_data_i  in  NB_DATA  data-memory debug read data
- mem_dirty_i  in  1  dirty bit of the addressed memory word
- reg_addr_o  out  NB_REG  register debug address
- reg_read_o  out  1  register debug read enable
- mem_addr_o  out  NB_MEM_ADDR  memory debug address
- mem_read_o  out  1  memory debug read enable
- tx_data_o  out  8  byte to transmit
- tx_start_o  out  1  1-cycle pulse: launch tx_data_o
- tx_done_i  in  1  1-cycle pulse: UART finished current byte
- busy_o  out  1  dump in progress
- done_o  out  1  1-cycle pulse: frame complete

Behaviour:
- Reset (reset_i=0, asynchronous): state IDLE; all outputs and counters 0.
- Frame byte order, all words MSB byte first:
  - 4 bytes PC, zero-extended.
  - 1 byte cycles_i.
  - 32x4 bytes for R0..R31.
  - For each address a=0..MEM_DEPTH-1 with dirty=1: 1 byte a, then 4 bytes data.
  - END_MARKER.
- PC and cycles_i are captured into internal registers on the cycle start_i is accepted; they are not re-sampled during the dump.
- Read ports are synchronous, latency 1:
  - Drive the address with read=1 for one cycle (REQ state).
  - Capture data/dirty on the next cycle (WAIT state).
  - read outputs are 0 in every other state.
- Byte handshake:
  - tx_start_o pulses for exactly one cycle.
  - tx_data_o holds stable from that pulse until tx_done_i.
  - The next tx_start_o is no earlier than the cycle after tx_done_i.
  - tx_done_i outside a byte wait is ignored.
- States and transitions:
  - IDLE: to LOAD on start_i; busy_o=1 from the next cycle.
  - LOAD -> SEND_PC (byte idx 3..0) -> SEND_CYC.
  - REG_REQ -> REG_WAIT -> REG_SEND (4 bytes); r++; at r=31 go to MEM_REQ, else back to REG_REQ.
  - MEM_REQ -> MEM_WAIT -> MEM_CHECK: dirty=0 skips; dirty=1 goes to MEM_SEND_ADDR -> MEM_SEND_DATA (4 bytes); then a++.
  - After a=MEM_DEPTH-1: SEND_END -> FINISH.
  - FINISH: done_o=1 for one cycle, busy_o=0, back to IDLE.
- Counters:
  - Register counter covers 0..31 without wrap aliasing; use a 6-bit internal counter or explicit last flag.
  - Memory counter terminates on MEM_DEPTH-1, not on overflow.
- Simultaneous events:
  - start_i in the same cycle as done_o: ignored; the new dump needs start_i in IDLE.
  - start_i during a dump: no effect.
- Reset mid-dump: immediate return to IDLE, tx_start_o=0, no partial END_MARKER.
- Byte count: 134 + 5*D, where D = number of dirty words.

Test Plan:
- Reset, then start with pc=0x0000001C, cycles=0x2A, regs Rn=n, no dirty words -> 134 bytes: 00 00 00 1C 2A, then 00 00 00 00 … 00 00 00 1F, then FF; done_o pulses once; busy_o=0 after.
- Words 3 and 31 dirty with data 0xDEADBEEF and 0x00000001 -> after register block: 03 DE AD BE EF 1F 00 00 00 01 FF; total 144 bytes.
- UART model with tx_done_i 1 cycle after start versus 1000 cycles after -> identical byte stream; never two tx_start_o without an intervening tx_done_i; tx_data_o stable while waiting.
- Spurious tx_done_i in IDLE, and start_i pulses mid-dump -> no extra bytes; frame unchanged.
- reset_i low during register byte 50, then release and start_i -> outputs 0 immediately; the new frame begins again with the PC MSB.
- Checker on the read ports -> reg_read_o asserted exactly 32 times, mem_read_o exactly MEM_DEPTH times; each data sample taken exactly 1 cycle after its address.

Source files
------------

// File: rtl/debug_dump_sequencer.sv
// Debug dump sequencer: after a halt/step, streams PC, cycle count, R0..R31 and
// every dirty data-memory word (address byte + word) to the UART, MSB first.
module debug_dump_sequencer #(
    parameter int          NB_DATA     = 32,
    parameter int          NB_PC       = 32,
    parameter int          N_BITS      = 8,
    parameter int          NB_REG      = 5,
    parameter int          NB_MEM_ADDR = 5,
    parameter int          MEM_DEPTH   = 32,
    parameter logic [7:0]  END_MARKER  = 8'hFF
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [NB_PC-1:0]       pc_i,
    input  logic [N_BITS-1:0]      cycles_i,
    input  logic [NB_DATA-1:0]     reg_data_i,
    input  logic [NB_DATA-1:0]     mem_data_i,
    input  logic                   mem_dirty_i,
    output logic [NB_REG-1:0]      reg_addr_o,
    output logic                   reg_read_o,
    output logic [NB_MEM_ADDR-1:0] mem_addr_o,
    output logic                   mem_read_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_start_o,
    input  logic                   tx_done_i,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic [3:0] {
        IDLE, LOAD, SEND_PC, SEND_CYC,
        REG_REQ, REG_WAIT, REG_SEND,
        MEM_REQ, MEM_WAIT, MEM_CHECK, MEM_SEND_ADDR, MEM_SEND_DATA,
        SEND_END, FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [N_BITS-1:0]    cyc_q, cyc_d;
    logic [NB_DATA-1:0]   word_q, word_d;
    logic                 dirty_q, dirty_d;
    logic [5:0]           reg_cnt_q, reg_cnt_d;
    logic [7:0]           mem_cnt_q, mem_cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic                 wait_q, wait_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;

    logic                 is_send;
    logic                 byte_done;
    logic                 mem_last;
    logic [7:0]           cur_byte;

    assign byte_done = wait_q && tx_done_i;
    assign mem_last  = (mem_cnt_q == 8'(MEM_DEPTH - 1));

    always_comb begin
        is_send  = 1'b0;
        cur_byte = 8'h00;
        case (state_q)
            SEND_PC:       begin is_send = 1'b1; cur_byte = pc_q[{idx_q, 3'b000} +: 8]; end
            SEND_CYC:      begin is_send = 1'b1; cur_byte = 8'(cyc_q); end
            REG_SEND,
            MEM_SEND_DATA: begin is_send = 1'b1; cur_byte = word_q[{idx_q, 3'b000} +: 8]; end
            MEM_SEND_ADDR: begin is_send = 1'b1; cur_byte = mem_cnt_q; end
            SEND_END:      begin is_send = 1'b1; cur_byte = END_MARKER; end
            default:       ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cyc_d      = cyc_q;
        word_d     = word_q;
        dirty_d    = dirty_q;
        reg_cnt_d  = reg_cnt_q;
        mem_cnt_d  = mem_cnt_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        // A byte is launched once per send-state entry/step; the launch waits
        // for the previous byte's done to clear the wait flag.
        if (is_send && !wait_q) begin
            tx_start_d = 1'b1;
            tx_data_d  = cur_byte;
            wait_d     = 1'b1;
        end
        if (byte_done) wait_d = 1'b0;

        case (state_q)
            IDLE: if (start_i) begin
                pc_d    = 32'(pc_i);
                cyc_d   = cycles_i;
                state_d = LOAD;
            end
            LOAD: begin
                reg_cnt_d = 6'd0;
                mem_cnt_d = 8'd0;
                idx_d     = 2'd3;
                state_d   = SEND_PC;
            end
            SEND_PC: if (byte_done) begin
                if (idx_q == 2'd0) state_d = SEND_CYC;
                else               idx_d   = idx_q - 2'd1;
            end
            SEND_CYC: if (byte_done) state_d = REG_REQ;
            REG_REQ:  state_d = REG_WAIT;
            REG_WAIT: begin
                word_d  = reg_data_i;
                idx_d   = 2'd3;
                state_d = REG_SEND;
            end
            REG_SEND: if (byte_done) begin
                if (idx_q != 2'd0) idx_d = idx_q - 2'd1;
                else begin
                    reg_cnt_d = reg_cnt_q + 6'd1;
                    state_d   = (reg_cnt_q == 6'd31) ? MEM_REQ : REG_REQ;
                end
            end
            MEM_REQ:  state_d = MEM_WAIT;
            MEM_WAIT: begin
                word_d  = mem_data_i;
                dirty_d = mem_dirty_i;
                state_d = MEM_CHECK;
            end
            MEM_CHECK: begin
                if (dirty_q)       state_d = MEM_SEND_ADDR;
                else if (mem_last) state_d = SEND_END;
                else begin
                    mem_cnt_d = mem_cnt_q + 8'd1;
                    state_d   = MEM_REQ;
                end
            end
            MEM_SEND_ADDR: if (byte_done) begin
                idx_d   = 2'd3;
                state_d = MEM_SEND_DATA;
            end
            MEM_SEND_DATA: if (byte_done) begin
                if (idx_q != 2'd0)  idx_d   = idx_q - 2'd1;
                else if (mem_last)  state_d = SEND_END;
                else begin
                    mem_cnt_d = mem_cnt_q + 8'd1;
                    state_d   = MEM_REQ;
                end
            end
            SEND_END: if (byte_done) state_d = FINISH;
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            cyc_q      <= '0;
            word_q     <= '0;
            dirty_q    <= 1'b0;
            reg_cnt_q  <= '0;
            mem_cnt_q  <= '0;
            idx_q      <= '0;
            wait_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cyc_q      <= cyc_d;
            word_q     <= word_d;
            dirty_q    <= dirty_d;
            reg_cnt_q  <= reg_cnt_d;
            mem_cnt_q  <= mem_cnt_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign reg_addr_o = reg_cnt_q[NB_REG-1:0];
    assign mem_addr_o = mem_cnt_q[NB_MEM_ADDR-1:0];
    assign reg_read_o = (state_q == REG_REQ);
    assign mem_read_o = (state_q == MEM_REQ);
    assign tx_data_o  = tx_data_q;
    assign tx_start_o = tx_start_q;
    assign busy_o     = (state_q != IDLE) && (state_q != FINISH);
    assign done_o     = (state_q == FINISH);

endmodule
